// File: rtl/econet_pkg.sv
// Shared types and constants for the Econet line interface.
package econet_pkg;

  localparam logic [7:0] ECONET_FLAG = 8'h7E;
  localparam logic [8:0] WORD_FLAG   = 9'h17E;

  typedef logic [8:0] word_t;

  typedef enum logic {
    HUNT,
    FRAME
  } rx_state_e;

endpackage

// File: rtl/econet_serial_port.sv
// One-bit-per-clock 9-bit serial link to the MCU: start 0, 9 data bits LSB first, stop 1.
module econet_serial_port
  import econet_pkg::*;
(
  input  logic  clock_24m,
  input  logic  reset_n,
  input  logic  rx_line,
  input  logic  rx_enable,
  output word_t rx_word,
  output logic  rx_valid,
  input  word_t tx_word,
  input  logic  tx_load,
  output logic  tx_line
);

  logic [3:0]  rx_cnt_q, rx_cnt_d;
  word_t       rx_sr_q, rx_sr_d;
  logic        rx_valid_q, rx_valid_d;
  logic [10:0] tx_sr_q, tx_sr_d;

  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_valid_d = 1'b0;
    if (!rx_enable) begin
      rx_cnt_d = '0;
    end else if (rx_cnt_q == 4'd0) begin
      if (!rx_line) rx_cnt_d = 4'd1;
    end else if (rx_cnt_q == 4'd10) begin
      // A bad stop bit silently drops the word.
      rx_valid_d = rx_line;
      rx_cnt_d   = '0;
    end else begin
      rx_sr_d  = {rx_line, rx_sr_q[8:1]};
      rx_cnt_d = rx_cnt_q + 4'd1;
    end
  end

  // A new word restarts the shifter, overwriting any word still going out.
  always_comb begin
    tx_sr_d = tx_load ? {1'b1, tx_word, 1'b0} : {1'b1, tx_sr_q[10:1]};
  end

  always_ff @(posedge clock_24m or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt_q   <= '0;
      rx_sr_q    <= '0;
      rx_valid_q <= 1'b0;
      tx_sr_q    <= '1;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_valid_q <= rx_valid_d;
      tx_sr_q    <= tx_sr_d;
    end
  end

  assign rx_word  = rx_sr_q;
  assign rx_valid = rx_valid_q;
  assign tx_line  = tx_sr_q[0];

endmodule

// File: rtl/econet.sv
// Econet line interface: HDLC framing with zero-stuffing between the MCU serial link and
// the Econet bus, plus optional Econet clock generation.
module econet
  import econet_pkg::*;
#(
  parameter int unsigned BUGGY_REV1_PCB  = 0,
  parameter int unsigned CLK_HIGH_CYCLES = 24,
  parameter int unsigned CLK_LOW_CYCLES  = 96
) (
  input  logic clock_24m,
  input  logic reset_n,
  input  logic serial_mcu_to_cpld,
  output logic serial_cpld_to_mcu,
  input  logic mcu_is_transmitting,
  output logic outputting_frame,
  output logic serial_buffer_empty,
  input  logic drive_econet_clock,
  input  logic econet_clock_R,
  output logic econet_clock_D,
  output logic econet_clock_DE,
  input  logic econet_data_R,
  output logic econet_data_D,
  output logic econet_data_DE
);

  localparam int unsigned Period = CLK_HIGH_CYCLES + CLK_LOW_CYCLES;
  localparam int unsigned CntW   = $clog2(Period);

  logic buggy_rev1_pcb;
  assign buggy_rev1_pcb = (BUGGY_REV1_PCB != 0);

  // Clock generation and input synchronisation
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic            gen_clk_q, gen_clk_d;
  logic            eclk_raw, eclk_s1_q, eclk_s2_q, eclk_s3_q;
  logic            data_s1_q, data_s2_q;
  logic            eclk_rise, eclk_fall;

  always_comb begin
    clk_cnt_d = (clk_cnt_q == CntW'(Period - 1)) ? '0 : clk_cnt_q + CntW'(1);
    gen_clk_d = (clk_cnt_d < CntW'(CLK_HIGH_CYCLES));
  end

  assign eclk_raw  = drive_econet_clock ? gen_clk_q : (econet_clock_R ^ buggy_rev1_pcb);
  assign eclk_rise = eclk_s2_q & ~eclk_s3_q;
  assign eclk_fall = ~eclk_s2_q & eclk_s3_q;

  always_ff @(posedge clock_24m or negedge reset_n) begin
    if (!reset_n) begin
      clk_cnt_q <= '0;
      gen_clk_q <= 1'b1;
      eclk_s1_q <= 1'b1;
      eclk_s2_q <= 1'b1;
      eclk_s3_q <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      gen_clk_q <= gen_clk_d;
      eclk_s1_q <= eclk_raw;
      eclk_s2_q <= eclk_s1_q;
      eclk_s3_q <= eclk_s2_q;
      data_s1_q <= econet_data_R ^ buggy_rev1_pcb;
      data_s2_q <= data_s1_q;
    end
  end

  assign econet_clock_D  = gen_clk_q;
  assign econet_clock_DE = drive_econet_clock;

  // MCU serial link
  word_t ser_rx_word, rx_word_q, rx_word_d;
  logic  ser_rx_valid, ser_tx_line, rx_emit_q, rx_emit_d;

  econet_serial_port u_serial_port (
    .clock_24m (clock_24m),
    .reset_n   (reset_n),
    .rx_line   (serial_mcu_to_cpld),
    .rx_enable (mcu_is_transmitting),
    .rx_word   (ser_rx_word),
    .rx_valid  (ser_rx_valid),
    .tx_word   (rx_word_q),
    .tx_load   (rx_emit_q),
    .tx_line   (ser_tx_line)
  );

  assign serial_cpld_to_mcu = ser_tx_line | mcu_is_transmitting;

  // HDLC transmitter
  logic       tx_active_q, tx_active_d, tx_flag_q, tx_flag_d, tx_stuff_q, tx_stuff_d;
  logic       tx_bit_q, tx_bit_d, buf_full_q, buf_full_d, emit, emit_bit;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [2:0] tx_cnt_q, tx_cnt_d, tx_ones_q, tx_ones_d;
  word_t      buf_q, buf_d, next_word;

  always_comb begin
    tx_active_d = tx_active_q;
    tx_flag_d   = tx_flag_q;
    tx_stuff_d  = tx_stuff_q;
    tx_bit_d    = tx_bit_q;
    tx_sr_d     = tx_sr_q;
    tx_cnt_d    = tx_cnt_q;
    tx_ones_d   = tx_ones_q;
    buf_full_d  = buf_full_q;
    buf_d       = buf_q;
    next_word   = WORD_FLAG;
    emit        = 1'b0;
    emit_bit    = 1'b1;
    if (eclk_fall) begin
      if (tx_active_q && tx_stuff_q) begin
        tx_bit_d   = 1'b0;
        tx_stuff_d = 1'b0;
        tx_ones_d  = '0;
      end else if (tx_active_q && tx_cnt_q != 3'd0) begin
        emit     = 1'b1;
        emit_bit = tx_sr_q[7];
        tx_sr_d  = {tx_sr_q[6:0], 1'b0};
        tx_cnt_d = tx_cnt_q - 3'd1;
      end else if (mcu_is_transmitting && (buf_full_q || (tx_active_q && !tx_flag_q))) begin
        // Underrun after a data byte fills with flags.
        next_word   = buf_full_q ? buf_q : WORD_FLAG;
        buf_full_d  = 1'b0;
        tx_active_d = 1'b1;
        tx_flag_d   = next_word[8];
        emit        = 1'b1;
        emit_bit    = next_word[7];
        tx_sr_d     = {next_word[6:0], 1'b0};
        tx_cnt_d    = 3'd7;
      end else begin
        tx_active_d = 1'b0;
        tx_bit_d    = 1'b1;
        tx_ones_d   = '0;
      end
    end
    if (emit) begin
      tx_bit_d = emit_bit;
      if (tx_flag_d || !emit_bit) begin
        tx_ones_d = '0;
      end else begin
        tx_ones_d  = tx_ones_q + 3'd1;
        tx_stuff_d = (tx_ones_q == 3'd4);
      end
    end
    if (ser_rx_valid) begin
      buf_d      = ser_rx_word;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock_24m or negedge reset_n) begin
    if (!reset_n) begin
      tx_active_q <= 1'b0;
      tx_flag_q   <= 1'b0;
      tx_stuff_q  <= 1'b0;
      tx_bit_q    <= 1'b1;
      tx_sr_q     <= '0;
      tx_cnt_q    <= '0;
      tx_ones_q   <= '0;
      buf_full_q  <= 1'b0;
      buf_q       <= '0;
    end else begin
      tx_active_q <= tx_active_d;
      tx_flag_q   <= tx_flag_d;
      tx_stuff_q  <= tx_stuff_d;
      tx_bit_q    <= tx_bit_d;
      tx_sr_q     <= tx_sr_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_ones_q   <= tx_ones_d;
      buf_full_q  <= buf_full_d;
      buf_q       <= buf_d;
    end
  end

  assign outputting_frame    = tx_active_q;
  assign serial_buffer_empty = ~buf_full_q;
  assign econet_data_DE      = tx_active_q;
  assign econet_data_D       = tx_bit_q;

  // HDLC receiver
  rx_state_e  rx_state_q, rx_state_d;
  logic [7:0] hunt_q, hunt_d, rx_sr_q, rx_sr_d;
  logic [2:0] rx_cnt_q, rx_cnt_d, rx_ones_q, rx_ones_d;
  logic       acc;

  always_comb begin
    rx_state_d = rx_state_q;
    hunt_d     = hunt_q;
    rx_sr_d    = rx_sr_q;
    rx_cnt_d   = rx_cnt_q;
    rx_ones_d  = rx_ones_q;
    rx_word_d  = rx_word_q;
    rx_emit_d  = 1'b0;
    acc        = 1'b0;
    if (mcu_is_transmitting) begin
      rx_state_d = HUNT;
      hunt_d     = '0;
      rx_cnt_d   = '0;
      rx_ones_d  = '0;
    end else if (eclk_rise) begin
      hunt_d = {hunt_q[6:0], data_s2_q};
      unique case (rx_state_q)
        HUNT: begin
          if (hunt_d == ECONET_FLAG) begin
            rx_state_d = FRAME;
            rx_word_d  = WORD_FLAG;
            rx_emit_d  = 1'b1;
            rx_cnt_d   = '0;
            rx_ones_d  = '0;
          end
        end
        FRAME: begin
          if (data_s2_q) begin
            if (rx_ones_q == 3'd6) begin
              rx_state_d = HUNT;
            end else begin
              rx_ones_d = rx_ones_q + 3'd1;
              acc       = 1'b1;
            end
          end else begin
            rx_ones_d = '0;
            if (rx_ones_q == 3'd6) begin
              rx_word_d = WORD_FLAG;
              rx_emit_d = 1'b1;
              rx_cnt_d  = '0;
            end else if (rx_ones_q != 3'd5) begin
              acc = 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (acc) begin
        rx_sr_d  = {rx_sr_q[6:0], data_s2_q};
        rx_cnt_d = rx_cnt_q + 3'd1;
        if (rx_cnt_q == 3'd7) begin
          rx_word_d = {1'b0, rx_sr_d};
          rx_emit_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_24m or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= HUNT;
      hunt_q     <= '0;
      rx_sr_q    <= '0;
      rx_cnt_q   <= '0;
      rx_ones_q  <= '0;
      rx_word_q  <= '0;
      rx_emit_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      hunt_q     <= hunt_d;
      rx_sr_q    <= rx_sr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_ones_q  <= rx_ones_d;
      rx_word_q  <= rx_word_d;
      rx_emit_q  <= rx_emit_d;
    end
  end

endmodule

// File: tb/tb_econet.sv
// Directed bench for econet: a normal board and a rev1 board (receivers inverted) side by side.
`timescale 1ns/1ps
module tb_econet;

  logic clock_24m = 1'b0;
  logic reset_n, ser_in, mcu_tx, drive_clk, eclk_line, edata_line;
  logic so [2];
  logic of [2];
  logic empty [2];
  logic ck_d [2];
  logic ck_de [2];
  logic d_d [2];
  logic d_de [2];

  int n_checks = 0;
  int n_errors = 0;

  bit          rxq[$];
  logic [8:0]  w0[$];
  logic [8:0]  w1[$];
  logic [63:0] cap0, cap1;
  int          ncap0, ncap1;

  always #21 clock_24m = ~clock_24m;

  econet #(.BUGGY_REV1_PCB(0)) u_dut0 (
    .clock_24m           (clock_24m),
    .reset_n             (reset_n),
    .serial_mcu_to_cpld  (ser_in),
    .serial_cpld_to_mcu  (so[0]),
    .mcu_is_transmitting (mcu_tx),
    .outputting_frame    (of[0]),
    .serial_buffer_empty (empty[0]),
    .drive_econet_clock  (drive_clk),
    .econet_clock_R      (eclk_line),
    .econet_clock_D      (ck_d[0]),
    .econet_clock_DE     (ck_de[0]),
    .econet_data_R       (edata_line),
    .econet_data_D       (d_d[0]),
    .econet_data_DE      (d_de[0])
  );

  econet #(.BUGGY_REV1_PCB(1)) u_dut1 (
    .clock_24m           (clock_24m),
    .reset_n             (reset_n),
    .serial_mcu_to_cpld  (ser_in),
    .serial_cpld_to_mcu  (so[1]),
    .mcu_is_transmitting (mcu_tx),
    .outputting_frame    (of[1]),
    .serial_buffer_empty (empty[1]),
    .drive_econet_clock  (drive_clk),
    .econet_clock_R      (~eclk_line),
    .econet_clock_D      (ck_d[1]),
    .econet_clock_DE     (ck_de[1]),
    .econet_data_R       (~edata_line),
    .econet_data_D       (d_d[1]),
    .econet_data_DE      (d_de[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // External Econet clock, 1 us high / 4 us low; RX bits change on its falling edge and
  // the driven data line is captured on its rising edge.
  initial begin
    eclk_line  = 1'b1;
    edata_line = 1'b1;
    forever begin
      repeat (24) @(negedge clock_24m);
      eclk_line  = 1'b0;
      edata_line = (rxq.size() > 0) ? rxq.pop_front() : 1'b1;
      repeat (96) @(negedge clock_24m);
      eclk_line = 1'b1;
      if (d_de[0]) begin cap0 = {cap0[62:0], d_d[0]}; ncap0++; end
      if (d_de[1]) begin cap1 = {cap1[62:0], d_d[1]}; ncap1++; end
    end
  end

  // Decode words the DUTs send to the MCU.
  initial begin
    int         cnt [2];
    logic [8:0] sh [2];
    cnt[0] = 0;
    cnt[1] = 0;
    forever begin
      @(negedge clock_24m);
      for (int d = 0; d < 2; d++) begin
        if (cnt[d] == 0) begin
          if (so[d] == 1'b0) cnt[d] = 1;
        end else if (cnt[d] < 10) begin
          sh[d][cnt[d]-1] = so[d];
          cnt[d]++;
        end else begin
          if (d == 0) w0.push_back(so[d] ? sh[d] : 9'h1FF);
          else        w1.push_back(so[d] ? sh[d] : 9'h1FF);
          cnt[d] = 0;
        end
      end
    end
  end

  task automatic wait_bits(input int n);
    repeat (n * 120) @(negedge clock_24m);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) rxq.push_back(b[i]);
  endtask

  task automatic drain_rx();
    int t = 0;
    while (rxq.size() > 0 && t < 30000) begin
      @(negedge clock_24m);
      t++;
    end
    check("rx_drain", t < 30000, 1);
    wait_bits(3);
  endtask

  task automatic send_word(input logic [8:0] w);
    int t = 0;
    @(negedge clock_24m);
    while (!(empty[0] && empty[1]) && t < 3000) begin
      @(negedge clock_24m);
      t++;
    end
    check("buf_wait", t < 3000, 1);
    ser_in = 1'b0;
    @(negedge clock_24m);
    for (int i = 0; i < 9; i++) begin
      ser_in = w[i];
      @(negedge clock_24m);
    end
    ser_in = 1'b1;
    @(negedge clock_24m);
  endtask

  task automatic expect_words(input string tag, input logic [8:0] exp [], input int n);
    logic [8:0] g;
    check({tag, "_n0"}, w0.size(), n);
    check({tag, "_n1"}, w1.size(), n);
    for (int i = 0; i < n; i++) begin
      g = (w0.size() > 0) ? w0.pop_front() : 9'h1FF;
      check({tag, "_w0"}, g, exp[i]);
      g = (w1.size() > 0) ? w1.pop_front() : 9'h1FF;
      check({tag, "_w1"}, g, exp[i]);
    end
    w0.delete();
    w1.delete();
  endtask

  initial begin
    logic [8:0]  exp_w [];
    logic [63:0] exp_tx;
    int          t, hi, lo;
    reset_n   = 1'b0;
    ser_in    = 1'b1;
    mcu_tx    = 1'b0;
    drive_clk = 1'b0;
    repeat (5) @(negedge clock_24m);
    for (int d = 0; d < 2; d++) begin
      check("rst_ser", so[d], 1);
      check("rst_empty", empty[d], 1);
      check("rst_of", of[d], 0);
      check("rst_dd", d_d[d], 1);
      check("rst_dde", d_de[d], 0);
      check("rst_ckd", ck_d[d], 1);
      check("rst_ckde", ck_de[d], 0);
    end
    reset_n = 1'b1;

    // Idle line, then bytes containing no flag pattern.
    wait_bits(10);
    push_byte(8'h55);
    push_byte(8'h33);
    push_byte(8'hAA);
    drain_rx();
    check("idle_n0", w0.size(), 0);
    check("idle_n1", w1.size(), 0);
    check("idle_so0", so[0], 1);
    check("idle_so1", so[1], 1);

    // Frame receive with a stuffed 0xFF and a closing flag, then idle 1s.
    push_byte(8'h7E);
    push_byte(8'hAA);
    push_byte(8'h55);
    push_byte(8'hAA);
    for (int i = 0; i < 9; i++) rxq.push_back((i == 5) ? 1'b0 : 1'b1);
    push_byte(8'h00);
    push_byte(8'h7E);
    drain_rx();
    wait_bits(10);
    exp_w = new[7];
    exp_w = '{9'h17E, 9'h0AA, 9'h055, 9'h0AA, 9'h0FF, 9'h000, 9'h17E};
    expect_words("rx", exp_w, 7);

    // Abort: eight 1s end the frame; data is ignored until the next flag.
    push_byte(8'h7E);
    push_byte(8'hAA);
    push_byte(8'hFF);
    push_byte(8'h55);
    push_byte(8'h33);
    drain_rx();
    exp_w = new[2];
    exp_w = '{9'h17E, 9'h0AA};
    expect_words("abort", exp_w, 2);
    push_byte(8'h7E);
    drain_rx();
    exp_w = new[1];
    exp_w = '{9'h17E};
    expect_words("resync", exp_w, 1);

    // Transmit a frame.
    mcu_tx = 1'b1;
    repeat (4) @(negedge clock_24m);
    cap0 = '0;
    cap1 = '0;
    ncap0 = 0;
    ncap1 = 0;
    send_word(9'h17E);
    send_word(9'h07E);
    check("tx_of0", of[0], 1);
    check("tx_of1", of[1], 1);
    check("tx_de0", d_de[0], 1);
    check("tx_de1", d_de[1], 1);
    send_word(9'h042);
    send_word(9'h0FF);
    send_word(9'h17E);
    t = 0;
    while ((of[0] || of[1]) && t < 20000) begin
      @(negedge clock_24m);
      t++;
    end
    check("tx_end_wait", t < 20000, 1);
    wait_bits(1);
    exp_tx = {22'd0, 8'b01111110, 9'b011111010, 8'b01000010, 9'b111110111, 8'b01111110};
    check("tx_nbits0", ncap0, 42);
    check("tx_nbits1", ncap1, 42);
    check("tx_bits0", cap0, exp_tx);
    check("tx_bits1", cap1, exp_tx);
    for (int d = 0; d < 2; d++) begin
      check("tx_end_of", of[d], 0);
      check("tx_end_de", d_de[d], 0);
      check("tx_end_d", d_d[d], 1);
      check("tx_empty", empty[d], 1);
      check("tx_ser_hold", so[d], 1);
    end

    // Generated Econet clock.
    drive_clk = 1'b1;
    repeat (2) @(negedge clock_24m);
    for (int d = 0; d < 2; d++) begin
      check("gen_de", ck_de[d], 1);
      t = 0;
      while (ck_d[d] && t < 300) begin @(negedge clock_24m); t++; end
      while (!ck_d[d] && t < 300) begin @(negedge clock_24m); t++; end
      check("gen_sync", t < 300, 1);
      hi = 0;
      while (ck_d[d] && hi < 500) begin hi++; @(negedge clock_24m); end
      lo = 0;
      while (!ck_d[d] && lo < 500) begin lo++; @(negedge clock_24m); end
      check("gen_high", hi, 24);
      check("gen_low", lo, 96);
    end
    drive_clk = 1'b0;
    repeat (2) @(negedge clock_24m);
    check("gen_off0", ck_de[0], 0);
    check("gen_off1", ck_de[1], 0);

    // Reset in the middle of a frame with a word buffered.
    send_word(9'h17E);
    t = 0;
    while (!(of[0] && of[1]) && t < 3000) begin @(negedge clock_24m); t++; end
    check("mid_start", t < 3000, 1);
    send_word(9'h042);
    repeat (2) @(negedge clock_24m);
    check("mid_full0", empty[0], 0);
    check("mid_full1", empty[1], 0);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("mid_rst_de", d_de[d], 0);
      check("mid_rst_of", of[d], 0);
      check("mid_rst_empty", empty[d], 1);
      check("mid_rst_d", d_d[d], 1);
    end
    @(negedge clock_24m);
    reset_n = 1'b1;
    repeat (4) @(negedge clock_24m);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
